// File: rtl/calc_entry_sequencer.sv
// Keypad calculator control FSM: assembles two BCD operands from key events,
// runs the BCD adder through a start/done handshake and drives the display value.
module calc_entry_sequencer #(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  add_done,
  input  logic [4*DIGITS+3:0]   add_result,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  output logic                  add_start,
  output logic [4*DIGITS-1:0]   disp_value,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_ENTER_B = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_SHOW    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d, disp_q, disp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            start_q, start_d, err_q, err_d;
  logic            is_dig, is_add, is_eq, is_clr, can_shift;

  always_comb begin
    is_dig    = key_valid && (key_code <= 4'd9);
    is_add    = key_valid && (key_code == 4'hA);
    is_eq     = key_valid && (key_code == 4'hB);
    is_clr    = key_valid && (key_code == 4'hC);
    can_shift = (cnt_q != CW'(DIGITS));

    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      S_ENTER_A: begin
        if (is_dig) begin
          if (can_shift) begin
            opa_d = (opa_q << 4) | W'(key_code);
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_add) begin
          opb_d   = '0;
          cnt_d   = '0;
          state_d = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        if (is_dig) begin
          if (can_shift) begin
            opb_d = (opb_q << 4) | W'(key_code);
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_eq) begin
          state_d = S_START;
        end
      end
      S_START: begin
        tcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // add_done takes priority over the timeout in the same cycle
        if (add_done) begin
          res_d   = add_result[W-1:0];
          state_d = (add_result[W+3:W] != 4'd0) ? S_ERR : S_SHOW;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_SHOW: begin
        if (is_dig) begin
          opa_d   = W'(key_code);
          cnt_d   = CW'(1);
          state_d = S_ENTER_A;
        end else if (is_add) begin
          opa_d   = res_q;
          opb_d   = '0;
          cnt_d   = '0;
          state_d = S_ENTER_B;
        end
      end
      S_ERR:   ;
      default: state_d = S_ENTER_A;
    endcase

    if (is_clr && (state_q != S_WAIT)) begin
      opa_d   = '0;
      opb_d   = '0;
      cnt_d   = '0;
      state_d = S_ENTER_A;
    end

    // Outputs derive from the next state so they are registered with it
    start_d = (state_d == S_START);
    err_d   = (state_d == S_ERR);
    case (state_d)
      S_ENTER_A: disp_d = opa_d;
      S_ENTER_B: disp_d = opb_d;
      S_SHOW:    disp_d = res_d;
      S_ERR:     disp_d = '0;
      default:   disp_d = disp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ENTER_A;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign op_a       = opa_q;
  assign op_b       = opb_q;
  assign add_start  = start_q;
  assign disp_value = disp_q;
  assign err        = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Self-checking bench for calc_entry_sequencer: keypad sequences, adder handshake,
// timeout, ignored inputs and reset during an addition.
module tb_calc_entry_sequencer;
  localparam int unsigned TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        add_done = 1'b0;
  logic [15:0] add_result = 16'h0;
  logic [11:0] op_a, op_b, disp_value;
  logic        add_start, err;
  logic [2:0]  state_dbg;

  int passed = 0;
  int total  = 0;
  int starts = 0;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [39:0] fin;
  } exp_t;
  exp_t sb[$];

  calc_entry_sequencer #(.DIGITS(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .add_done(add_done), .add_result(add_result), .op_a(op_a), .op_b(op_b),
    .add_start(add_start), .disp_value(disp_value), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (add_start === 1'b1) starts++;

  function automatic logic [39:0] snap();
    return {op_a, op_b, disp_value, state_dbg, err};
  endfunction

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (add_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Adder stand-in: add_done pulses lat cycles after the add_start cycle
  task automatic respond(input int lat, input logic [15:0] resp);
    repeat (lat) @(negedge clk);
    add_done   = 1'b1;
    add_result = resp;
    @(negedge clk);
    add_done   = 1'b0;
  endtask

  task automatic run_add(input string name, input logic [11:0] a, input logic [11:0] b,
                         input int lat, input logic [15:0] resp, input logic [39:0] fin);
    exp_t e;
    bit seen;
    int s0;
    sb.push_back('{a: a, b: b, fin: fin});
    s0 = starts;
    press(4'hB);
    wait_start(seen);
    total++;
    if (!seen) $display("FAIL %s_start: add_start never seen, want 1", name);
    else passed++;
    e = sb.pop_front();
    total++;
    if ({op_a, op_b} !== {e.a, e.b})
      $display("FAIL %s_ops: got %h/%h want %h/%h", name, op_a, op_b, e.a, e.b);
    else passed++;
    respond(lat, resp);
    total++;
    if (snap() !== e.fin) $display("FAIL %s_result: got %h want %h", name, snap(), e.fin);
    else passed++;
    total++;
    if (starts - s0 != 1) $display("FAIL %s_pulses: got %0d want 1", name, starts - s0);
    else passed++;
  endtask

  task automatic test_reset();
    logic [39:0] e;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    e = '0;
    total++;
    if (snap() !== e || add_start !== 1'b0)
      $display("FAIL reset: got %h start %b want %h start 0", snap(), add_start, e);
    else passed++;
  endtask

  task automatic test_basic_add();
    logic [39:0] e;
    press(4'h1); press(4'h2); press(4'h3);
    e = {12'h123, 12'h000, 12'h123, 3'd0, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL enter_a: got %h want %h", snap(), e); else passed++;
    press(4'hA); press(4'h4); press(4'h5);
    e = {12'h123, 12'h045, 12'h045, 3'd1, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL enter_b: got %h want %h", snap(), e); else passed++;
    run_add("basic", 12'h123, 12'h045, 2, 16'h0168, {12'h123, 12'h045, 12'h168, 3'd4, 1'b0});
  endtask

  task automatic test_show_chain();
    logic [39:0] e;
    press(4'hA);
    e = {12'h168, 12'h000, 12'h000, 3'd1, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL chain_plus: got %h want %h", snap(), e); else passed++;
    press(4'h1);
    run_add("chain", 12'h168, 12'h001, 1, 16'h0169, {12'h168, 12'h001, 12'h169, 3'd4, 1'b0});
    press(4'h7);
    e = {12'h007, 12'h001, 12'h007, 3'd0, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL show_digit: got %h want %h", snap(), e); else passed++;
  endtask

  task automatic test_overflow_err();
    logic [39:0] e;
    press(4'hC);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    e = {12'h987, 12'h000, 12'h987, 3'd0, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL digit_limit: got %h want %h", snap(), e); else passed++;
    press(4'hA); press(4'h9); press(4'h9); press(4'h9);
    run_add("carry", 12'h987, 12'h999, 3, 16'h1986, {12'h987, 12'h999, 12'h000, 3'd5, 1'b1});
    press(4'h3); press(4'hA); press(4'hB);
    e = {12'h987, 12'h999, 12'h000, 3'd5, 1'b1};
    total++;
    if (snap() !== e) $display("FAIL err_hold: got %h want %h", snap(), e); else passed++;
    press(4'hC);
    e = '0;
    total++;
    if (snap() !== e) $display("FAIL err_clear: got %h want %h", snap(), e); else passed++;
  endtask

  task automatic test_timeout();
    logic [39:0] e;
    bit seen;
    press(4'h1); press(4'hA); press(4'h2); press(4'hB);
    wait_start(seen);
    repeat (TIMEOUT) @(negedge clk);
    total++;
    if (state_dbg !== 3'd3) $display("FAIL timeout_early: got state %0d want 3", state_dbg);
    else passed++;
    @(negedge clk);
    e = {12'h001, 12'h002, 12'h000, 3'd5, 1'b1};
    total++;
    if (snap() !== e) $display("FAIL timeout_err: got %h want %h", snap(), e); else passed++;
    press(4'hC);
    press(4'h1); press(4'hA); press(4'h2);
    run_add("tie", 12'h001, 12'h002, TIMEOUT, 16'h0042, {12'h001, 12'h002, 12'h042, 3'd4, 1'b0});
    press(4'hC);
  endtask

  task automatic test_ignored();
    logic [39:0] e;
    press(4'h5);
    @(negedge clk);
    add_done = 1'b1; add_result = 16'h0999;
    @(negedge clk);
    add_done = 1'b0;
    press(4'hB); press(4'hE);
    e = {12'h005, 12'h000, 12'h005, 3'd0, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL ignore_enter_a: got %h want %h", snap(), e); else passed++;
    press(4'hA); press(4'hA); press(4'h3); press(4'hF);
    e = {12'h005, 12'h003, 12'h003, 3'd1, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL ignore_enter_b: got %h want %h", snap(), e); else passed++;
    press(4'hB);
    press(4'h1); press(4'hC); press(4'hA);
    e = {12'h005, 12'h003, 12'h003, 3'd3, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL ignore_wait: got %h want %h", snap(), e); else passed++;
    respond(1, 16'h0008);
    e = {12'h005, 12'h003, 12'h008, 3'd4, 1'b0};
    total++;
    if (snap() !== e) $display("FAIL after_wait: got %h want %h", snap(), e); else passed++;
    press(4'hC);
  endtask

  task automatic test_reset_in_wait();
    logic [39:0] e;
    int s0;
    press(4'h2); press(4'hA); press(4'h3); press(4'hB);
    repeat (3) @(negedge clk);
    total++;
    if (state_dbg !== 3'd3) $display("FAIL pre_reset_wait: got state %0d want 3", state_dbg);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    respond(0, 16'h0005);
    repeat (3) @(negedge clk);
    e = '0;
    total++;
    if (snap() !== e || starts != s0)
      $display("FAIL reset_wait: got %h starts %0d want %h starts %0d", snap(), starts, e, s0);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_show_chain();
    test_overflow_err();
    test_timeout();
    test_ignored();
    test_reset_in_wait();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_left: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
